// File: rtl/sb_spram_multi.sv
// sb_spram_multi - parametrised single-port SRAM model with power-state FSM.
//
// Sits between the midgetv core and on-chip RAM. It has configurable width,
// depth and read latency, a per-nibble write mask, a wake-up delay after
// OFF/SLEEP, and a READY/RVALID handshake.
//
// Parameters:
//   DW       data width, multiple of 4 (one mask bit per nibble)
//   DEPTH    number of words (any value, need not be a power of two)
//   AW       address width, 2**AW >= DEPTH
//   RDLAT    read latency in clocks, 1 or 2
//   WAKE_CYC cycles spent in WAKE after OFF/SLEEP, 1..255
//   IDLEVAL  DATAOUT value when no valid data (zero-extended/truncated to DW)
//
// Ports:
//   CLOCK      in   rising-edge clock
//   RESET_N    in   asynchronous active-low reset
//   DATAIN     in   write data
//   ADDRESS    in   word address
//   MASKWREN   in   nibble write enables, bit i covers DATAIN[4i+3:4i]
//   WREN       in   1 = write, 0 = read
//   CHIPSELECT in   access request
//   POWERON    in   1 = powered
//   STANDBY    in   standby request
//   SLEEP      in   sleep request
//   READY      out  state is ON; a CHIPSELECT this cycle is accepted
//   DATAOUT    out  read data
//   RVALID     out  DATAOUT belongs to the access accepted RDLAT cycles ago
//
// Configuration macro:
//   SB_SPRAM_WRTHRU_EN  a write returns the merged new word instead of the
//                       word as it was before the write.

module sb_spram_multi #(
    parameter int unsigned DW       = 16,
    parameter int unsigned DEPTH    = 16384,
    parameter int unsigned AW       = 14,
    parameter int unsigned RDLAT    = 1,
    parameter int unsigned WAKE_CYC = 3,
    parameter logic [31:0] IDLEVAL  = 32'hdead
) (
    input  logic              CLOCK,
    input  logic              RESET_N,
    input  logic [DW-1:0]     DATAIN,
    input  logic [AW-1:0]     ADDRESS,
    input  logic [DW/4-1:0]   MASKWREN,
    input  logic              WREN,
    input  logic              CHIPSELECT,
    input  logic              POWERON,
    input  logic              STANDBY,
    input  logic              SLEEP,
    output logic              READY,
    output logic [DW-1:0]     DATAOUT,
    output logic              RVALID
);

    localparam int unsigned NB        = DW / 4;
    localparam int unsigned IW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [DW-1:0] IDLE_W  = DW'(IDLEVAL);
    localparam logic [7:0] WAKE_LOAD  = 8'(WAKE_CYC);
    // One extra bit so DEPTH == 2**AW is representable.
    localparam logic [AW:0] DEPTH_W   = (AW + 1)'(DEPTH);

    typedef enum logic [2:0] {StOff, StSleep, StStby, StWake, StOn} state_e;

    state_e      state_q;
    logic [7:0]  wake_cnt_q;
    logic        ready_q;

    // Power FSM. Condition priority: !POWERON > SLEEP > STANDBY > normal.
    // ready_q is set together with the transition into ON so READY is high
    // from the first ON cycle.
    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q    <= StOff;
            wake_cnt_q <= 8'd0;
            ready_q    <= 1'b0;
        end else begin
            ready_q <= 1'b0;
            if (!POWERON) begin
                state_q <= StOff;
            end else if (SLEEP) begin
                state_q <= StSleep;
            end else if (STANDBY) begin
                state_q <= StStby;
            end else begin
                unique case (state_q)
                    StOff, StSleep: begin
                        state_q    <= StWake;
                        wake_cnt_q <= WAKE_LOAD;
                    end
                    StStby: begin
                        state_q <= StOn;
                        ready_q <= 1'b1;
                    end
                    StWake: begin
                        if (wake_cnt_q <= 8'd1) begin
                            state_q <= StOn;
                            ready_q <= 1'b1;
                        end else begin
                            wake_cnt_q <= wake_cnt_q - 8'd1;
                        end
                    end
                    StOn: begin
                        ready_q <= 1'b1;
                    end
                    default: begin
                        state_q <= StOff;
                    end
                endcase
            end
        end
    end

    assign READY = ready_q;

    // Access path
    logic [DW-1:0] mem [DEPTH];
    logic [IW-1:0] addr_idx;
    logic          in_range;
    logic          accept;
    logic [DW-1:0] old_word;
    logic [DW-1:0] merged_word;
    logic [DW-1:0] rd_word;

    assign addr_idx = ADDRESS[IW-1:0];
    assign in_range = ({1'b0, ADDRESS} < DEPTH_W);
    assign accept   = ready_q & CHIPSELECT;
    assign old_word = mem[addr_idx];

    always_comb begin
        merged_word = old_word;
        for (int i = 0; i < int'(NB); i++) begin
            if (MASKWREN[i]) begin
                merged_word[4*i +: 4] = DATAIN[4*i +: 4];
            end
        end
    end

`ifdef SB_SPRAM_WRTHRU_EN
    assign rd_word = !in_range ? IDLE_W : (WREN ? merged_word : old_word);
`else
    assign rd_word = in_range ? old_word : IDLE_W;
`endif

    // Array is deliberately not reset; out-of-range writes are dropped.
    always_ff @(posedge CLOCK) begin
        if (accept && WREN && in_range) begin
            mem[addr_idx] <= merged_word;
        end
    end

    // First read stage: every accepted access produces a result.
    logic          rv1_q;
    logic [DW-1:0] rd1_q;

    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            rv1_q <= 1'b0;
            rd1_q <= IDLE_W;
        end else begin
            rv1_q <= accept;
            rd1_q <= accept ? rd_word : IDLE_W;
        end
    end

    // The pipeline runs independently of the power state, so reads already
    // in flight complete even after leaving ON.
    if (RDLAT == 2) begin : g_lat2
        logic          rv2_q;
        logic [DW-1:0] rd2_q;

        always_ff @(posedge CLOCK or negedge RESET_N) begin
            if (!RESET_N) begin
                rv2_q <= 1'b0;
                rd2_q <= IDLE_W;
            end else begin
                rv2_q <= rv1_q;
                rd2_q <= rd1_q;
            end
        end

        assign RVALID  = rv2_q;
        assign DATAOUT = rd2_q;
    end else begin : g_lat1
        assign RVALID  = rv1_q;
        assign DATAOUT = rd1_q;
    end

endmodule

// File: tb/tb_sb_spram_multi.sv
// Bench for sb_spram_multi: two instances (RDLAT=1 and RDLAT=2) share the
// same stimulus; outputs are compared every cycle with a behavioural model.

module tb_sb_spram_multi;

    localparam int unsigned DEPTH = 1000;
    localparam int unsigned WAKE  = 3;
    localparam logic [15:0] IDLE  = 16'hdead;

    logic        clk;
    logic        rst_n;
    logic [15:0] din;
    logic [9:0]  addr;
    logic [3:0]  mask;
    logic        we, cs, pon, stb, slp;

    logic        ready1, rvalid1, ready2, rvalid2;
    logic [15:0] dout1, dout2;

    sb_spram_multi #(
        .DW(16), .DEPTH(DEPTH), .AW(10), .RDLAT(1), .WAKE_CYC(WAKE), .IDLEVAL(32'hdead)
    ) dut1 (
        .CLOCK(clk), .RESET_N(rst_n), .DATAIN(din), .ADDRESS(addr), .MASKWREN(mask),
        .WREN(we), .CHIPSELECT(cs), .POWERON(pon), .STANDBY(stb), .SLEEP(slp),
        .READY(ready1), .DATAOUT(dout1), .RVALID(rvalid1)
    );

    sb_spram_multi #(
        .DW(16), .DEPTH(DEPTH), .AW(10), .RDLAT(2), .WAKE_CYC(WAKE), .IDLEVAL(32'hdead)
    ) dut2 (
        .CLOCK(clk), .RESET_N(rst_n), .DATAIN(din), .ADDRESS(addr), .MASKWREN(mask),
        .WREN(we), .CHIPSELECT(cs), .POWERON(pon), .STANDBY(stb), .SLEEP(slp),
        .READY(ready2), .DATAOUT(dout2), .RVALID(rvalid2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model state
    logic [15:0] m_mem [1024];
    int          m_run;    // consecutive normal powered cycles
    int          m_need;   // normal cycles needed before ready
    logic        m_ready;
    logic        hv [1:2];
    logic [15:0] hd [1:2];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_assert++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic rst_model();
        m_run   = 0;
        m_need  = WAKE + 1;
        m_ready = 1'b0;
        for (int i = 1; i <= 2; i++) begin
            hv[i] = 1'b0;
            hd[i] = IDLE;
        end
    endtask

    // Model one clock edge with the current inputs, then check both DUTs.
    task automatic cycle();
        logic        acc;
        logic [15:0] old, bm, mrg, res;
        acc = m_ready && cs;
        res = IDLE;
        if (acc && addr < DEPTH) begin
            old = m_mem[addr];
            bm  = {{4{mask[3]}}, {4{mask[2]}}, {4{mask[1]}}, {4{mask[0]}}};
            mrg = (old & ~bm) | (din & bm);
            res = old;
`ifdef SB_SPRAM_WRTHRU_EN
            if (we) res = mrg;
`endif
            if (we) m_mem[addr] = mrg;
        end
        if (!pon || slp) begin
            m_need = WAKE + 1;
            m_run  = 0;
        end else if (stb) begin
            m_need = 1;
            m_run  = 0;
        end else if (m_run < 1000) begin
            m_run++;
        end
        m_ready = (m_run >= m_need);
        hv[2] = hv[1];
        hd[2] = hd[1];
        hv[1] = acc;
        hd[1] = res;
        @(posedge clk);
        @(negedge clk);
        check("ready1", ready1, m_ready);
        check("ready2", ready2, m_ready);
        check("rvalid1", rvalid1, hv[1]);
        check("dout1", dout1, hd[1]);
        check("rvalid2", rvalid2, hv[2]);
        check("dout2", dout2, hd[2]);
    endtask

    task automatic step(input logic c, input logic w, input logic [9:0] a,
                        input logic [15:0] d, input logic [3:0] m);
        cs   = c;
        we   = w;
        addr = a;
        din  = d;
        mask = m;
        cycle();
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_rdy1"}, ready1, 1'b0);
        check({tag, "_rdy2"}, ready2, 1'b0);
        check({tag, "_rv1"}, rvalid1, 1'b0);
        check({tag, "_rv2"}, rvalid2, 1'b0);
        check({tag, "_do1"}, dout1, IDLE);
        check({tag, "_do2"}, dout2, IDLE);
    endtask

    function automatic logic [9:0] pool_addr(input int r);
        return (r < 16) ? 10'(r) : 10'(974 + r);
    endfunction

    initial begin
        int low;
        int r;
        pon = 1'b1; slp = 1'b0; stb = 1'b0;
        cs = 1'b0; we = 1'b0; addr = '0; din = '0; mask = '0;
        rst_n = 1'b0;
        rst_model();
        @(posedge clk);
        @(negedge clk);
        check_idle("reset");
        rst_n = 1'b1;

        // Power-up wake delay
        low = 0;
        for (int g = 0; g < 20 && ready1 !== 1'b1; g++) begin
            step(1'b0, 1'b0, '0, '0, '0);
            if (ready1 !== 1'b1) low++;
        end
        check("t1_wake_cycles", low, WAKE);

        // Initialise every in-range address the random phase may read
        for (int i = 0; i < 26; i++) begin
            step(1'b1, 1'b1, pool_addr(i), 16'($urandom), 4'hF);
        end

        // Full write then read back
        step(1'b1, 1'b1, 10'd5, 16'h1234, 4'hF);
        step(1'b1, 1'b0, 10'd5, 16'h0000, 4'h0);
        check("t2_rv", rvalid1, 1'b1);
        check("t2_rd", dout1, 16'h1234);

        // Masked write
        step(1'b1, 1'b1, 10'd5, 16'hABCD, 4'b0101);
`ifdef SB_SPRAM_WRTHRU_EN
        check("t3_wr_result", dout1, 16'h1B3D);
`else
        check("t3_wr_result", dout1, 16'h1234);
`endif
        step(1'b1, 1'b0, 10'd5, 16'h0000, 4'h0);
        check("t3_rd", dout1, 16'h1B3D);

        // Out of range
        step(1'b1, 1'b1, 10'd999, 16'h5A5A, 4'hF);
        step(1'b1, 1'b1, 10'd1000, 16'h1111, 4'hF);
        step(1'b1, 1'b0, 10'd1000, 16'h0000, 4'h0);
        check("t4_oor_rv", rvalid1, 1'b1);
        check("t4_oor_rd", dout1, IDLE);
        step(1'b1, 1'b0, 10'd999, 16'h0000, 4'h0);
        check("t4_999", dout1, 16'h5A5A);

        // One-cycle sleep pulse while requesting accesses
        slp = 1'b1;
        step(1'b1, 1'b0, 10'd5, '0, '0);
        slp = 1'b0;
        low = (ready1 !== 1'b1) ? 1 : 0;
        for (int g = 0; g < 20 && ready1 !== 1'b1; g++) begin
            step(1'b1, 1'b0, 10'd5, '0, '0);
            if (ready1 !== 1'b1) low++;
        end
        check("t5_sleep_low", low, WAKE + 1);

        // RDLAT=2 reads interrupted by reset
        step(1'b1, 1'b0, 10'd5, '0, '0);
        step(1'b1, 1'b0, 10'd999, '0, '0);
        check("t6_inflight_rv2", rvalid2, 1'b1);
        addr  = 10'd5;
        rst_n = 1'b0;
        #1;
        check_idle("t6_async");
        rst_model();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int g = 0; g < WAKE + 1; g++) step(1'b0, 1'b0, '0, '0, '0);
        step(1'b1, 1'b0, 10'd5, '0, '0);
        check("t6_mem_kept1", dout1, 16'h1B3D);
        step(1'b0, 1'b0, '0, '0, '0);
        check("t6_mem_kept2", dout2, 16'h1B3D);

        // Randomised traffic with occasional power events
        for (int n = 0; n < 400; n++) begin
            r = int'($urandom_range(0, 31));
            pon = (r != 0 && r != 3);
            slp = (r == 1 || r == 3 || r == 4);
            stb = (r == 2 || r == 3 || r == 4);
            step(($urandom_range(0, 3) != 0), 1'($urandom), pool_addr(int'($urandom_range(0, 39))),
                 16'($urandom), 4'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
